mmio_dmem_bridge: RTL

- Sits between the processor's data-memory port and the dmem syncram.
- Adds a parametrised memory-mapped I/O window of NUM_CH channels. Each channel has an RX FIFO fed by a peripheral through a valid/ready handshake, a TX register with a one-cycle strobe, and an interrupt enable.
- Accesses outside the window pass through to dmem unchanged.
- Generalises the fixed single-dmem hookup to N peripheral channels (keyboard, display, timers) without processor changes.

---
 rtl/mmio_dmem_bridge.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mmio_dmem_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_dmem_bridge: dmem pass-through with an NUM_CH-channel MMIO window      |
// | (RX FIFO, TX strobe register, irq enable). Option: MMIO_TIMESTAMP_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mmio_dmem_bridge #(
  parameter int              ADDR_W     = 12,
  parameter int              DATA_W     = 32,
  parameter int              NUM_CH     = 4,
  parameter int              FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 12'hF00
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        cpu_address,
  input  logic [DATA_W-1:0]        cpu_data,
  input  logic                     cpu_wren,
  output logic [DATA_W-1:0]        cpu_q,
  output logic [ADDR_W-1:0]        dmem_address,
  output logic [DATA_W-1:0]        dmem_data,
  output logic                     dmem_wren,
  input  logic [DATA_W-1:0]        dmem_q,
  input  logic [NUM_CH-1:0]        ch_in_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_in_data,
  output logic [NUM_CH-1:0]        ch_in_ready,
  output logic [NUM_CH*DATA_W-1:0] ch_out_data,
  output logic [NUM_CH-1:0]        ch_out_strobe,
  output logic                     irq
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [ADDR_W:0]   c_base = {1'b0, MMIO_BASE};
  localparam logic [ADDR_W:0]   c_end  = c_base + (ADDR_W+1)'(NUM_CH*4 + 1);
  localparam logic [ADDR_W-1:0] c_ts_off = ADDR_W'(NUM_CH*4);

  logic                  w_hit, w_ch_hit, w_ts_hit;
  logic [ADDR_W-1:0]     w_off;
  logic [3:0]            w_ch;
  logic [1:0]            w_reg;
  logic [NUM_CH-1:0]     w_sel, w_push, w_pop, w_nonempty;
  logic [DATA_W-1:0]     w_mmio_rdata, w_ts;
  logic [DATA_W-1:0]     w_head   [NUM_CH];
  logic [DATA_W-1:0]     w_status [NUM_CH];

  logic [DATA_W-1:0]     r_mem    [NUM_CH][FIFO_DEPTH];
  logic [c_ptr_w-1:0]    r_rd_ptr [NUM_CH];
  logic [c_ptr_w-1:0]    r_wr_ptr [NUM_CH];
  logic [c_cnt_w-1:0]    r_count  [NUM_CH];
  logic [NUM_CH-1:0][DATA_W-1:0] r_tx;
  logic [NUM_CH-1:0]     r_strobe, r_irqen;
  logic                  r_irq;

  assign w_hit    = ({1'b0, cpu_address} >= c_base) && ({1'b0, cpu_address} < c_end);
  assign w_off    = cpu_address - MMIO_BASE;
  assign w_ch     = w_off[5:2];
  assign w_reg    = w_off[1:0];
  assign w_ch_hit = w_hit && (w_off < c_ts_off);
  assign w_ts_hit = w_hit && (w_off == c_ts_off);

  assign dmem_address  = cpu_address;
  assign dmem_data     = cpu_data;
  assign dmem_wren     = cpu_wren && !w_hit;
  assign cpu_q         = w_hit ? w_mmio_rdata : dmem_q;
  assign ch_out_data   = r_tx;
  assign ch_out_strobe = r_strobe;
  assign irq           = r_irq;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c]       = w_ch_hit && (w_ch == 4'(c));
      w_nonempty[c]  = (r_count[c] != '0);
      ch_in_ready[c] = (r_count[c] != c_cnt_w'(FIFO_DEPTH));
      w_push[c]      = ch_in_valid[c] && ch_in_ready[c];
      // Popping an empty FIFO is dropped here so pointers never move on it.
      w_pop[c]       = w_sel[c] && cpu_wren && (w_reg == 2'd1) && cpu_data[0]
                       && w_nonempty[c];
      w_head[c]      = w_nonempty[c] ? r_mem[c][r_rd_ptr[c]] : '0;
      w_status[c]    = '0;
      w_status[c][8 +: c_cnt_w] = r_count[c];
      w_status[c][1] = !ch_in_ready[c];
      w_status[c][0] = w_nonempty[c];
    end
  end

  always_comb begin
    w_mmio_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_sel[c]) begin
        case (w_reg)
          2'd0:    w_mmio_rdata = w_head[c];
          2'd1:    w_mmio_rdata = w_status[c];
          2'd2:    w_mmio_rdata = r_tx[c];
          default: w_mmio_rdata = {{(DATA_W-1){1'b0}}, r_irqen[c]};
        endcase
      end
    end
    if (w_ts_hit) w_mmio_rdata = w_ts;
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c]) r_mem[c][r_wr_ptr[c]] <= ch_in_data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_rd_ptr[c] <= '0;
        r_wr_ptr[c] <= '0;
        r_count[c]  <= '0;
      end
      r_tx     <= '0;
      r_strobe <= '0;
      r_irqen  <= '0;
      r_irq    <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
        if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
        case ({w_push[c], w_pop[c]})
          2'b10:   r_count[c] <= r_count[c] + 1'b1;
          2'b01:   r_count[c] <= r_count[c] - 1'b1;
          default: r_count[c] <= r_count[c];
        endcase
        r_strobe[c] <= w_sel[c] && cpu_wren && (w_reg == 2'd2);
        if (w_sel[c] && cpu_wren && (w_reg == 2'd2)) r_tx[c] <= cpu_data;
        if (w_sel[c] && cpu_wren && (w_reg == 2'd3)) r_irqen[c] <= cpu_data[0];
      end
      r_irq <= |(r_irqen & w_nonempty);
    end
  end

`ifdef MMIO_TIMESTAMP_EN
  logic [DATA_W-1:0] r_ts;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    r_ts <= '0;
    else if (w_ts_hit && cpu_wren) r_ts <= '0;
    else                           r_ts <= r_ts + 1'b1;
  end

  assign w_ts = r_ts;
`else
  assign w_ts = '0;
`endif

endmodule
`default_nettype wire
